// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch display path: digit positions and
// active-high 7-segment glyphs ordered {g,f,e,d,c,b,a}.
package stopwatch_pkg;

    localparam int unsigned N_DIGITS_DEFAULT = 9;

    localparam int unsigned IDX_MILI  = 0;
    localparam int unsigned IDX_CENT  = 1;
    localparam int unsigned IDX_DECI  = 2;
    localparam int unsigned IDX_USEG  = 3;
    localparam int unsigned IDX_DSEG  = 4;
    localparam int unsigned IDX_UMIN  = 5;
    localparam int unsigned IDX_DMIN  = 6;
    localparam int unsigned IDX_UHORA = 7;
    localparam int unsigned IDX_DHORA = 8;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/stopwatch_display_scan_if.sv
// Digit bus from the stopwatch counter plus the multiplexed display drive.
interface stopwatch_display_scan_if #(
    parameter int unsigned N_DIGITS = stopwatch_pkg::N_DIGITS_DEFAULT
) ();
    logic [4*N_DIGITS-1:0] digits_bcd;
    logic [N_DIGITS-1:0]   dp_mask;
    logic                  lz_en;
    logic                  enable;
    logic [6:0]            seg;
    logic                  dp;
    logic [N_DIGITS-1:0]   an;
    logic                  frame_tick;

    modport master (
        output digits_bcd, dp_mask, lz_en, enable,
        input  seg, dp, an, frame_tick
    );

    modport slave (
        input  digits_bcd, dp_mask, lz_en, enable,
        output seg, dp, an, frame_tick
    );
endinterface

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-high 7-segment glyph; 10-15 render as a dash.
module bcd_to_7seg
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] glyph_c
);
    always_comb begin
        glyph_c = SEG_DASH;
        case (bcd)
            4'd0:    glyph_c = SEG_0;
            4'd1:    glyph_c = SEG_1;
            4'd2:    glyph_c = SEG_2;
            4'd3:    glyph_c = SEG_3;
            4'd4:    glyph_c = SEG_4;
            4'd5:    glyph_c = SEG_5;
            4'd6:    glyph_c = SEG_6;
            4'd7:    glyph_c = SEG_7;
            4'd8:    glyph_c = SEG_8;
            4'd9:    glyph_c = SEG_9;
            default: glyph_c = SEG_DASH;
        endcase
    end
endmodule

// File: rtl/stopwatch_display_scan.sv
// Time-multiplexed 7-segment scanner: latches one frame per scan, blanks
// leading zeros and opens each anode only after a short anti-ghosting gap.
module stopwatch_display_scan
    import stopwatch_pkg::*;
#(
    parameter int unsigned N_DIGITS       = N_DIGITS_DEFAULT,
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned BLANK_CYCLES   = 500,
    parameter int unsigned LZ_STOP        = IDX_USEG,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    stopwatch_display_scan_if.slave  bus
);
    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned DIG_W = 4 * N_DIGITS;

    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]    CNT_OPEN = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [6:0]          SEG_POL  = {7{SEG_ACTIVE_LOW}};
    localparam logic [N_DIGITS-1:0] AN_POL   = {N_DIGITS{AN_ACTIVE_LOW}};

    logic [CNT_W-1:0]    cnt_q, cnt_nxt;
    logic [IDX_W-1:0]    idx_q, idx_nxt;
    logic [DIG_W-1:0]    fdig_q, fdig_nxt;
    logic [N_DIGITS-1:0] fdp_q, fdp_nxt;
    logic                flz_q, flz_nxt;
    logic                slot_end, frame_load;

    logic [N_DIGITS-1:0] blank, an_sel;
    logic                zero_run, cur_dp, cur_blank, an_on;
    logic [3:0]          cur_bcd;
    logic [6:0]          glyph, seg_nxt;

    logic [6:0]          seg_q;
    logic                dp_q;
    logic [N_DIGITS-1:0] an_q;
    logic                frame_tick_q;

    // Scan timing and frame capture
    always_comb begin
        slot_end   = (cnt_q == CNT_LAST);
        frame_load = slot_end && (idx_q == IDX_LAST);
        cnt_nxt    = slot_end ? '0 : cnt_q + CNT_W'(1);
        idx_nxt    = idx_q;
        if (frame_load)    idx_nxt = '0;
        else if (slot_end) idx_nxt = idx_q + IDX_W'(1);
        fdig_nxt = frame_load ? bus.digits_bcd : fdig_q;
        fdp_nxt  = frame_load ? bus.dp_mask    : fdp_q;
        flz_nxt  = frame_load ? bus.lz_en      : flz_q;
    end

    // Outputs are computed from next-state so they line up with the slot
    always_comb begin
        zero_run = flz_nxt;
        blank    = '0;
        for (int i = int'(N_DIGITS) - 1; i >= 0; i--) begin
            zero_run = zero_run && (fdig_nxt[4*i +: 4] == 4'd0);
            blank[i] = zero_run && (i > int'(LZ_STOP));
        end
        cur_bcd   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        an_sel    = '0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (idx_nxt == IDX_W'(i)) begin
                cur_bcd   = fdig_nxt[4*i +: 4];
                cur_dp    = fdp_nxt[i];
                cur_blank = blank[i];
                an_sel[i] = 1'b1;
            end
        end
        an_on   = bus.enable && (cnt_nxt >= CNT_OPEN);
        seg_nxt = cur_blank ? SEG_OFF : glyph;
    end

    bcd_to_7seg u_dec (
        .bcd     (cur_bcd),
        .glyph_c (glyph)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= IDX_W'(IDX_MILI);
            fdig_q       <= '0;
            fdp_q        <= '0;
            flz_q        <= 1'b0;
            frame_tick_q <= 1'b0;
            seg_q        <= SEG_POL;
            dp_q         <= SEG_ACTIVE_LOW;
            an_q         <= AN_POL;
        end else begin
            cnt_q        <= cnt_nxt;
            idx_q        <= idx_nxt;
            fdig_q       <= fdig_nxt;
            fdp_q        <= fdp_nxt;
            flz_q        <= flz_nxt;
            frame_tick_q <= frame_load;
            seg_q        <= seg_nxt ^ SEG_POL;
            dp_q         <= cur_dp ^ SEG_ACTIVE_LOW;
            an_q         <= (an_on ? an_sel : '0) ^ AN_POL;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.an         = an_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_stopwatch_display_scan.sv
// Bench for stopwatch_display_scan: table vectors, corner sequences and
// random input churn, all checked against a cycle-count based model.
module tb_stopwatch_display_scan;

    localparam int unsigned ND = 9;
    localparam int unsigned SD = 4;
    localparam int unsigned FRAME = ND * SD;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stopwatch_display_scan_if #(.N_DIGITS(ND)) bus ();

    stopwatch_display_scan #(
        .N_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(1), .LZ_STOP(3),
        .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests  = 0;
    int errors = 0;
    int t      = 0;   // clk edges since reset release

    // model state: frame being shown and enable seen at the last edge
    logic [35:0] m_dig;
    logic [8:0]  m_dp;
    logic        m_lz;
    logic        m_en;

    logic [6:0] glyph_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                   7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    typedef struct {
        logic [35:0] dig;
        logic [8:0]  dpm;
        logic        lz;
        logic        en;
        logic [6:0]  s0, s4, s5;
    } vec_t;
    vec_t vecs [5];

    function automatic logic [6:0] glyph(input logic [3:0] v);
        if (v < 4'd10) return glyph_tbl[v];
        return 7'h40;
    endfunction

    function automatic void model(output logic [6:0] es, output logic ed,
                                  output logic [8:0] ea, output logic ef);
        int slot, ph;
        logic blank;
        slot  = (t / int'(SD)) % int'(ND);
        ph    = t % int'(SD);
        blank = m_lz && (slot > 3);
        for (int j = slot; j < int'(ND); j++)
            if (m_dig[4*j +: 4] != 4'd0) blank = 1'b0;
        es = blank ? 7'h7F : ~glyph(m_dig[4*slot +: 4]);
        ed = ~m_dp[slot];
        ea = (m_en && ph >= 1) ? ~(9'b1 << slot) : 9'h1FF;
        ef = (t % int'(FRAME) == 0);
    endfunction

    task automatic check(input string nm, input logic [35:0] act, input logic [35:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0d: got %0h expected %0h", nm, t, act, exp);
        end
    endtask

    task automatic check_idle(input string nm);
        check({nm, "_an"},  36'(bus.an),  36'h1FF);
        check({nm, "_seg"}, 36'(bus.seg), 36'h7F);
        check({nm, "_dp"},  36'(bus.dp),  36'h1);
        check({nm, "_ft"},  36'(bus.frame_tick), 36'h0);
    endtask

    // one clock edge, updating the model and checking every output
    task automatic tick();
        logic [6:0] es;
        logic       ed, ef;
        logic [8:0] ea;
        if (t % int'(FRAME) == int'(FRAME) - 1) begin
            m_dig = bus.digits_bcd;
            m_dp  = bus.dp_mask;
            m_lz  = bus.lz_en;
        end
        m_en = bus.enable;
        @(posedge clk);
        #1;
        t++;
        model(es, ed, ea, ef);
        check("seg", 36'(bus.seg), 36'(es));
        check("dp",  36'(bus.dp),  36'(ed));
        check("an",  36'(bus.an),  36'(ea));
        check("frame_tick", 36'(bus.frame_tick), 36'(ef));
    endtask

    task automatic model_reset();
        t = 0; m_dig = '0; m_dp = '0; m_lz = 1'b0; m_en = 1'b0;
    endtask

    task automatic apply(input logic [35:0] d, input logic [8:0] p,
                         input logic lz, input logic en);
        bus.digits_bcd = d; bus.dp_mask = p; bus.lz_en = lz; bus.enable = en;
    endtask

    task automatic sync_frame();
        tick();
        while (t % int'(FRAME) != 0) tick();
    endtask

    task automatic run_to(input int phase);
        tick();
        while (t % int'(FRAME) != phase) tick();
    endtask

    task automatic rand_inputs();
        logic [35:0] d;
        int top, v;
        top = int'($urandom_range(0, 8));
        for (int i = 0; i < 9; i++) begin
            v = int'($urandom_range(0, 15));
            if (v > 9 && $urandom_range(0, 3) != 0) v = v - 10;
            if (i > top) v = 0;
            d[4*i +: 4] = 4'(v);
        end
        apply(d, 9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 5) != 0));
    endtask

    initial begin
        int n;
        vecs[0] = '{36'h987654321, 9'b0_1010_1000, 1'b0, 1'b1, 7'h79, 7'h12, 7'h02};
        vecs[1] = '{36'h000001234, 9'b0_0000_0000, 1'b1, 1'b1, 7'h19, 7'h7F, 7'h7F};
        vecs[2] = '{36'h000000000, 9'b0_0000_1000, 1'b1, 1'b1, 7'h40, 7'h7F, 7'h7F};
        vecs[3] = '{36'h000C00000, 9'b1_0000_0000, 1'b1, 1'b1, 7'h40, 7'h40, 7'h3F};
        vecs[4] = '{36'h987654321, 9'b1_1111_1111, 1'b0, 1'b0, 7'h79, 7'h12, 7'h02};

        rst = 1'b1;
        apply('0, '0, 1'b0, 1'b1);
        model_reset();
        #12;
        check_idle("reset");
        #11;
        rst = 1'b0;

        // first frame_tick lands 36 edges after release
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.frame_tick && n < 100);
        check("first_frame_tick_cycle", 36'(n), 36'd36);

        foreach (vecs[k]) begin
            apply(vecs[k].dig, vecs[k].dpm, vecs[k].lz, vecs[k].en);
            sync_frame();
            for (int c = 0; c < int'(FRAME); c++) begin
                tick();
                if (t % int'(FRAME) == 2)  check($sformatf("vec%0d_slot0", k), 36'(bus.seg), 36'(vecs[k].s0));
                if (t % int'(FRAME) == 18) check($sformatf("vec%0d_slot4", k), 36'(bus.seg), 36'(vecs[k].s4));
                if (t % int'(FRAME) == 22) check($sformatf("vec%0d_slot5", k), 36'(bus.seg), 36'(vecs[k].s5));
            end
        end

        // mid-frame input change stays invisible until the next latch
        apply(36'h987654321, 9'b0_1010_1000, 1'b0, 1'b1);
        sync_frame();
        run_to(9);
        apply(36'h111111111, 9'b0, 1'b0, 1'b1);
        run_to(26);
        check("midframe_old_slot6", 36'(bus.seg), 36'h78);
        run_to(26);
        check("midframe_new_slot6", 36'(bus.seg), 36'h79);

        // asynchronous reset in the middle of slot 6
        run_to(25);
        #3;
        rst = 1'b1;
        #1;
        check_idle("async_reset");
        @(posedge clk);
        #1;
        check_idle("reset_hold");
        rst = 1'b0;
        model_reset();
        tick();
        check("restart_idx0_an", 36'(bus.an), 36'h1FE);

        // random input churn at arbitrary points in the scan
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 7) == 0) rand_inputs();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
